byte_capture: RTL and testbench
===============================

Name: byte_capture

Overview:
- Sink-side counterpart to the byte-stream source: accepts a stream of bytes, one per handshake, and stores them into an internal N-entry buffer.
- Signals `done` when N bytes have been captured.
- Keeps a running mod-256 checksum.
- Exposes a registered read-back port so downstream logic and benches can inspect the captured bytes (e.g. the "%PDF%PDF" signature).

Parameters:
- N, 8, number of bytes captured per run (N >= 2).
- AW, 3, address width; must equal clog2(N).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse that arms a capture run.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  byte from source.
- in_ready  output  1  sink accepts a byte this cycle.
- rd_addr  input  AW  read-back address.
- rd_data  output  8  buffer byte at rd_addr; 1-cycle latency.
- count  output  AW+1  bytes captured in current run, 0..N.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE (level).
- overflow  output  1  sticky: a byte was offered while DONE.
- checksum  output  8  sum of captured bytes mod 256.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; count=0, checksum=0, done=0, busy=0, overflow=0, rd_data=0.
  - Buffer contents are not cleared.
  - rst has priority over every other input; reset mid-capture abandons the run, and bytes already written stay in the buffer.
- in_ready is combinational: in_ready = (state==CAPTURE). An accept is in_valid && in_ready at a posedge.
- States:
  - IDLE:
    - in_ready=0; in_valid is ignored and does not set overflow.
    - start -> CAPTURE; count<=0, checksum<=0, overflow<=0.
  - CAPTURE:
    - busy=1. On accept: mem[count[AW-1:0]]<=in_data, count<=count+1, checksum<=checksum+in_data (8-bit wrap).
    - If the accept makes count==N -> DONE on that edge; done=1 and busy=0 in the next cycle.
    - Bubbles (in_valid=0) are allowed and hold all state.
    - start is ignored in CAPTURE, and a byte offered in the same cycle is still accepted.
  - DONE:
    - in_ready=0. in_valid=1 sets overflow<=1; overflow stays set until the next start or rst.
    - start -> CAPTURE; count<=0, checksum<=0, done<=0, overflow<=0. A simultaneous in_valid is not accepted (in_ready=0 that cycle) and does not set overflow.
- count never exceeds N, and the write address never wraps within a run.
- Read-back:
  - rd_data<=mem[rd_addr] every cycle in every state.
  - Same-cycle write and read to the same address returns the old contents.
  - rd_addr >= N returns an undefined value; benches must not check it.
- Output timing: all outputs except in_ready are registered.

Test Plan:
- Basic capture: rst, then start, then stream 25 50 44 46 25 50 44 46 back-to-back -> in_ready high 8 cycles; done=1 with count=8 and checksum=0xFE; rd_addr 0..7 returns those bytes one cycle later.
- Bubbles: same 8 bytes with in_valid low every other cycle -> identical buffer, count=8, checksum=0xFE; done asserts only after the 8th accept.
- Overflow: after done, drive in_valid=1 with 0xAA -> in_ready=0, overflow=1, count stays 8, buffer unchanged; a following start clears overflow, done and count.
- Idle / ignored start:
  - in_valid=1 in IDLE -> no write, count=0, overflow=0.
  - start pulse at byte 3 of a run -> ignored; run completes at 8 bytes.
- Reset mid-run: rst after 5 bytes -> IDLE with count=0, done=0, busy=0. Then start plus 8 bytes of 0xFF -> checksum=0xF8.
- Checksum wrap: bytes 80 80 80 80 80 80 80 81 -> checksum=0x01.

Source files
------------

// File: rtl/byte_capture.sv
// Sink for a handshaked byte stream: captures N bytes into a local buffer,
// keeps a mod-256 checksum and offers a registered read-back port.
module byte_capture #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [7:0]    checksum
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [AW:0] LAST = (AW+1)'(N-1);

  state_t      state, state_nx;
  logic        accept;
  logic [7:0]  mem [0:(1<<AW)-1];

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: if (accept && count == LAST) state_nx = DONE;
      DONE:    if (start) state_nx = CAPTURE;
      default: state_nx = IDLE;
    endcase
  end

  // Status flags decode straight from the state register, so they carry no
  // combinational path from inputs except in_ready.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      CAPTURE: begin in_ready = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      checksum <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      case (state)
        IDLE: if (start) begin
          count    <= '0;
          checksum <= '0;
          overflow <= 1'b0;
        end
        CAPTURE: if (accept) begin
          count    <= count + (AW+1)'(1);
          checksum <= checksum + in_data;
        end
        DONE: begin
          if (start) begin
            count    <= '0;
            checksum <= '0;
            overflow <= 1'b0;
          end else if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer is deliberately not reset; a reset mid-run leaves written bytes.
  always_ff @(posedge clk) begin
    if (accept) mem[count[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_byte_capture.sv
// Directed bench for byte_capture: a transaction-level model (captured-byte
// queue plus shadow buffer) checked every cycle, plus literal spot checks.
module tb_byte_capture;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic          in_valid = 0;
  logic [7:0]    in_data = 0;
  logic          in_ready;
  logic [AW-1:0] rd_addr = 0;
  logic [7:0]    rd_data;
  logic [AW:0]   count;
  logic          busy, done, overflow;
  logic [7:0]    checksum;

  byte_capture #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data), .count(count),
    .busy(busy), .done(done), .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=capturing 2=finished; run contents as a queue.
  int         ph = 0;
  bit         armed = 0;
  logic [7:0] q[$];
  logic [7:0] m_mem [N];
  bit         m_known [N];
  bit         m_ovf = 0;
  logic [7:0] m_rd = 0;
  bit         m_rd_ok = 0;

  function automatic logic [7:0] qsum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s[7:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; ph = 0; q.delete(); m_ovf = 0; m_rd = 0; m_rd_ok = 1;
    end else begin
      m_rd    = m_mem[rd_addr];
      m_rd_ok = m_known[rd_addr];
      if (ph == 0) begin
        if (start) begin ph = 1; q.delete(); m_ovf = 0; end
      end else if (ph == 1) begin
        if (in_valid) begin
          m_mem[q.size()] = in_data;
          m_known[q.size()] = 1;
          q.push_back(in_data);
          if (q.size() == N) ph = 2;
        end
      end else begin
        if (start) begin ph = 1; q.delete(); m_ovf = 0; end
        else if (in_valid) m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, ph == 1);
      chk("busy", busy, ph == 1);
      chk("done", done, ph == 2);
      chk("count", count, q.size());
      chk("checksum", checksum, qsum());
      chk("overflow", overflow, m_ovf);
      if (m_rd_ok) chk("rd_data", rd_data, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1; in_data = b; tick(); in_valid = 0;
  endtask

  task automatic arm();
    start = 1; tick(); start = 0;
  endtask

  logic [7:0] pdf [N] = '{8'h25, 8'h50, 8'h44, 8'h46, 8'h25, 8'h50, 8'h44, 8'h46};

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_rd", rd_data, 0);

    // basic back-to-back run
    arm();
    for (int i = 0; i < N; i++) send(pdf[i]);
    chk("basic_done", done, 1);
    chk("basic_count", count, 8);
    chk("basic_cksum", checksum, 8'hFE);
    for (int i = 0; i < N; i++) begin
      rd_addr = i[AW-1:0]; tick();
      chk("basic_rd", rd_data, pdf[i]);
    end

    // bubbles between bytes
    arm();
    for (int i = 0; i < N; i++) begin
      send(pdf[i]);
      if (i < N-1) chk("bub_notdone", done, 0);
      tick();
    end
    chk("bub_count", count, 8);
    chk("bub_cksum", checksum, 8'hFE);

    // overflow while finished
    rd_addr = 0;
    in_valid = 1; in_data = 8'hAA;
    chk("ovf_ready", in_ready, 0);
    tick(); in_valid = 0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    tick();
    chk("ovf_rd0", rd_data, 8'h25);
    arm();
    chk("ovf_clr", overflow, 0);
    chk("ovf_done_clr", done, 0);
    chk("ovf_count_clr", count, 0);

    // start pulse inside a run is ignored, the byte still lands
    for (int i = 0; i < N; i++) begin
      start = (i == 2);
      send(8'(i + 1));
      start = 0;
    end
    chk("ign_done", done, 1);
    chk("ign_cksum", checksum, 8'h24);

    // offers in idle do nothing
    rst = 1; tick(); rst = 0;
    in_valid = 1; in_data = 8'h77; tick(); tick(); in_valid = 0;
    chk("idle_count", count, 0);
    chk("idle_ovf", overflow, 0);
    rd_addr = 0; tick();
    chk("idle_rd0", rd_data, 8'h01);

    // reset mid-run
    arm();
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
    rst = 1; tick(); rst = 0;
    chk("mid_count", count, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    rd_addr = 4; tick();
    chk("mid_keep", rd_data, 8'h14);
    arm();
    for (int i = 0; i < N; i++) send(8'hFF);
    chk("ff_cksum", checksum, 8'hF8);

    // start with simultaneous offer in DONE: no accept, no overflow
    start = 1; in_valid = 1; in_data = 8'h80; tick(); start = 0; in_valid = 0;
    chk("restart_count", count, 0);
    chk("restart_ovf", overflow, 0);

    // checksum wrap
    for (int i = 0; i < N; i++) send(i == N-1 ? 8'h81 : 8'h80);
    chk("wrap_cksum", checksum, 8'h01);
    chk("wrap_done", done, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
